cam_emulator: RTL and testbench

- Synthetic OV7670-style camera source driving the same pins the camera capture path receives: pixel clock, vsync, href and an 8-bit data bus.
- Data is RGB565, sent as two bytes per pixel, high byte first.
- Generates built-in test patterns so the capture, rotate, grayscale and frame-buffer path can be checked without a physical camera, in simulation or on a loopback Pmod.
- Runs on the 65 MHz system clock.

---
 rtl/cam_emulator.sv | 248 ++++++++++++++++++++++++
 tb/tb_cam_emulator.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_emulator.sv
// rtl/cam_emulator.sv - synthetic OV7670-style RGB565 camera source with built-in test patterns
//
// Ports:
//   clk             system clock
//   rst             asynchronous reset, active-high
//   enable_in       run frames continuously while high
//   pattern_sel_in  0 solid, 1 colour bars, 2 gray ramp, 3 checkerboard
//   solid_color_in  RGB565 colour for pattern 0
//   pclk_out        emulated pixel clock (DIV system clocks per period, starts low)
//   vsync_out       frame sync, active-high
//   href_out        line valid, high during active bytes
//   data_out        pixel byte, high byte of each RGB565 pixel first
//   frame_done_out  one-clk pulse when a frame finishes
//   frame_count_out completed frame count, wraps
//   busy_out        high whenever the generator is not idle
module cam_emulator #(
    parameter int WIDTH        = 320,
    parameter int HEIGHT       = 240,
    parameter int DIV          = 4,
    parameter int VSYNC_TICKS  = 2352,
    parameter int VBP_TICKS    = 2000,
    parameter int HBLANK_TICKS = 144,
    parameter int VFP_TICKS    = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable_in,
    input  logic [1:0]  pattern_sel_in,
    input  logic [15:0] solid_color_in,
    output logic        pclk_out,
    output logic        vsync_out,
    output logic        href_out,
    output logic [7:0]  data_out,
    output logic        frame_done_out,
    output logic [15:0] frame_count_out,
    output logic        busy_out
);

    localparam int MAXT_A = (VSYNC_TICKS > VBP_TICKS) ? VSYNC_TICKS : VBP_TICKS;
    localparam int MAXT_B = (HBLANK_TICKS > VFP_TICKS) ? HBLANK_TICKS : VFP_TICKS;
    localparam int MAXT   = (MAXT_A > MAXT_B) ? MAXT_A : MAXT_B;
    localparam int CW     = (MAXT > 1) ? $clog2(MAXT) : 1;
    localparam int DW     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW     = $clog2(2 * WIDTH);
    localparam int YW     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int BARW   = WIDTH / 8;
    localparam int BCW    = (BARW > 1) ? $clog2(BARW) : 1;

    typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, HBLANK, VFRONT} state_t;

    state_t          state_q;
    logic [DW-1:0]   div_q, div_d;
    logic            pclk_q, pclk_d;
    logic            tick;
    logic [CW-1:0]   cnt_q, cnt_lim;
    logic            cnt_last;
    logic [BW-1:0]   b_q;
    logic [YW-1:0]   y_q, y_pix;
    logic [BCW-1:0]  bar_cnt_q;
    logic [2:0]      bar_idx_q;
    logic            line_end_q;
    logic            last_byte;
    logic            emit;
    logic [1:0]      pat_q;
    logic [15:0]     solid_q;
    logic            vsync_q, href_q, frame_done_q;
    logic [7:0]      data_q, byte_nxt;
    logic [15:0]     frame_count_q;
    logic [15:0]     pix;
    logic [5:0]      xg;
    logic            y4;

    // tick is the cycle where the divider wraps, i.e. the pclk falling edge
    assign tick   = (div_q == DW'(DIV - 1));
    assign div_d  = tick ? '0 : div_q + DW'(1);
    assign pclk_d = (div_d >= DW'(DIV / 2));

    always_comb begin
        cnt_lim = '0;
        case (state_q)
            VSYNC:   cnt_lim = CW'(VSYNC_TICKS - 1);
            VBACK:   cnt_lim = CW'(VBP_TICKS - 1);
            HBLANK:  cnt_lim = CW'(HBLANK_TICKS - 1);
            VFRONT:  cnt_lim = CW'(VFP_TICKS - 1);
            default: cnt_lim = '0;
        endcase
    end
    assign cnt_last = (cnt_q == cnt_lim);

    // Line's first byte is emitted on the HBLANK->ACTIVE tick, before y_q advances
    assign y_pix = (state_q == HBLANK) ? y_q + YW'(1) : y_q;
    assign y4    = ((y_pix >> 4) & YW'(1)) != '0;
    // x[7:2] of the pixel being emitted (x = b >> 1)
    assign xg    = 6'(b_q >> 3);

    always_comb begin
        pix = 16'h0000;
        case (pat_q)
            2'd0: pix = solid_q;
            2'd1: begin
                case (bar_idx_q)
                    3'd0:    pix = 16'hFFFF;
                    3'd1:    pix = 16'hFFE0;
                    3'd2:    pix = 16'h07FF;
                    3'd3:    pix = 16'h07E0;
                    3'd4:    pix = 16'hF81F;
                    3'd5:    pix = 16'hF800;
                    3'd6:    pix = 16'h001F;
                    default: pix = 16'h0000;
                endcase
            end
            2'd2:    pix = {xg[5:1], xg, xg[5:1]};
            default: pix = (xg[2] ^ y4) ? 16'h0000 : 16'hFFFF;
        endcase
    end

    assign byte_nxt  = b_q[0] ? pix[7:0] : pix[15:8];
    assign last_byte = (b_q == BW'(2 * WIDTH - 1));
    assign emit      = tick && (((state_q == VBACK) && cnt_last) ||
                                ((state_q == ACTIVE) && !line_end_q) ||
                                ((state_q == HBLANK) && cnt_last && (y_q != YW'(HEIGHT - 1))));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            div_q         <= '0;
            pclk_q        <= 1'b0;
            cnt_q         <= '0;
            b_q           <= '0;
            y_q           <= '0;
            bar_cnt_q     <= '0;
            bar_idx_q     <= '0;
            line_end_q    <= 1'b0;
            pat_q         <= '0;
            solid_q       <= '0;
            vsync_q       <= 1'b0;
            href_q        <= 1'b0;
            data_q        <= '0;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
        end else begin
            div_q        <= div_d;
            pclk_q       <= pclk_d;
            frame_done_q <= 1'b0;
            if (tick) begin
                case (state_q)
                    IDLE: begin
                        vsync_q <= 1'b0;
                        href_q  <= 1'b0;
                        data_q  <= '0;
                        if (enable_in) begin
                            pat_q   <= pattern_sel_in;
                            solid_q <= solid_color_in;
                            y_q     <= '0;
                            cnt_q   <= '0;
                            vsync_q <= 1'b1;
                            state_q <= VSYNC;
                        end
                    end
                    VSYNC: begin
                        if (cnt_last) begin
                            cnt_q   <= '0;
                            vsync_q <= 1'b0;
                            state_q <= VBACK;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    VBACK: begin
                        if (cnt_last) begin
                            cnt_q   <= '0;
                            href_q  <= 1'b1;
                            state_q <= ACTIVE;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    ACTIVE: begin
                        if (line_end_q) begin
                            line_end_q <= 1'b0;
                            href_q     <= 1'b0;
                            data_q     <= '0;
                            cnt_q      <= '0;
                            state_q    <= HBLANK;
                        end
                    end
                    HBLANK: begin
                        if (cnt_last) begin
                            cnt_q <= '0;
                            if (y_q == YW'(HEIGHT - 1)) begin
                                state_q <= VFRONT;
                            end else begin
                                y_q     <= y_q + YW'(1);
                                href_q  <= 1'b1;
                                state_q <= ACTIVE;
                            end
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    VFRONT: begin
                        if (cnt_last) begin
                            cnt_q         <= '0;
                            frame_done_q  <= 1'b1;
                            frame_count_q <= frame_count_q + 16'd1;
                            if (enable_in) begin
                                pat_q   <= pattern_sel_in;
                                solid_q <= solid_color_in;
                                y_q     <= '0;
                                vsync_q <= 1'b1;
                                state_q <= VSYNC;
                            end else begin
                                state_q <= IDLE;
                            end
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    default: state_q <= IDLE;
                endcase

                if (emit) begin
                    data_q     <= byte_nxt;
                    b_q        <= last_byte ? '0 : b_q + BW'(1);
                    line_end_q <= last_byte;
                    // bar position advances once per pixel; it wraps to bar 0 at line end
                    if (b_q[0]) begin
                        if (bar_cnt_q == BCW'(BARW - 1)) begin
                            bar_cnt_q <= '0;
                            bar_idx_q <= bar_idx_q + 3'd1;
                        end else begin
                            bar_cnt_q <= bar_cnt_q + BCW'(1);
                        end
                    end
                end
            end
        end
    end

    assign pclk_out        = pclk_q;
    assign vsync_out       = vsync_q;
    assign href_out        = href_q;
    assign data_out        = data_q;
    assign frame_done_out  = frame_done_q;
    assign frame_count_out = frame_count_q;
    assign busy_out        = (state_q != IDLE);

endmodule

// File: tb/tb_cam_emulator.sv
// tb/tb_cam_emulator.sv - scoreboard testbench for cam_emulator
module tb_cam_emulator;

    localparam int W   = 16;
    localparam int H   = 4;
    localparam int DV  = 4;
    localparam int VS  = 2;
    localparam int VBP = 3;
    localparam int HB  = 2;
    localparam int VFP = 2;
    localparam int W2  = 64;
    localparam int H2  = 32;
    localparam int FRAME_TICKS = VS + VBP + H * (2 * W + HB) + VFP;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en, en2;
    logic [1:0]  psel, psel2;
    logic [15:0] solid, solid2;
    logic        pclk, vsync, href, fd, busy;
    logic [7:0]  data;
    logic [15:0] fcnt;
    logic        pclk2, vsync2, href2, fd2, busy2;
    logic [7:0]  data2;
    logic [15:0] fcnt2;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    logic [7:0] sb_q[$];
    logic [7:0] sb_q2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cam_emulator #(.WIDTH(W), .HEIGHT(H), .DIV(DV), .VSYNC_TICKS(VS), .VBP_TICKS(VBP),
                   .HBLANK_TICKS(HB), .VFP_TICKS(VFP)) u_dut (
        .clk(clk), .rst(rst), .enable_in(en), .pattern_sel_in(psel), .solid_color_in(solid),
        .pclk_out(pclk), .vsync_out(vsync), .href_out(href), .data_out(data),
        .frame_done_out(fd), .frame_count_out(fcnt), .busy_out(busy));

    cam_emulator #(.WIDTH(W2), .HEIGHT(H2), .DIV(DV), .VSYNC_TICKS(VS), .VBP_TICKS(VBP),
                   .HBLANK_TICKS(HB), .VFP_TICKS(VFP)) u_dut2 (
        .clk(clk), .rst(rst), .enable_in(en2), .pattern_sel_in(psel2), .solid_color_in(solid2),
        .pclk_out(pclk2), .vsync_out(vsync2), .href_out(href2), .data_out(data2),
        .frame_done_out(fd2), .frame_count_out(fcnt2), .busy_out(busy2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_pix(input int pat, input logic [15:0] sc,
                                              input int x, input int y, input int w);
        int r, g;
        case (pat)
            0: return sc;
            1: begin
                case (x / (w / 8))
                    0: return 16'hFFFF;
                    1: return 16'hFFE0;
                    2: return 16'h07FF;
                    3: return 16'h07E0;
                    4: return 16'hF81F;
                    5: return 16'hF800;
                    6: return 16'h001F;
                    default: return 16'h0000;
                endcase
            end
            2: begin
                r = (x % 256) / 8;
                g = (x % 256) / 4;
                return 16'(r * 2048 + g * 32 + r);
            end
            default: return ((((x / 16) + (y / 16)) % 2) == 0) ? 16'hFFFF : 16'h0000;
        endcase
    endfunction

    task automatic push_frame(input int which, input int pat, input logic [15:0] sc,
                              input int w, input int h);
        logic [15:0] p;
        logic [7:0]  bv;
        for (int y = 0; y < h; y++) begin
            for (int b = 0; b < 2 * w; b++) begin
                p  = model_pix(pat, sc, b / 2, y, w);
                bv = (b % 2 == 0) ? p[15:8] : p[7:0];
                if (which == 1) sb_q.push_back(bv);
                else            sb_q2.push_back(bv);
            end
        end
    endtask

    // DUT1 monitor: scoreboard on every pclk rising edge with href high, plus timing checks
    logic p_pclk = 1'b0, p_vs = 1'b0, p_href = 1'b0, p_fd = 1'b0;
    bit   first_line = 1'b0;
    int   vs_rise_c = 0, vs_fall_c = 0, href_rise_c = 0, href_fall_c = 0;
    int   vs_rises = 0, href_rises = 0, fd_count = 0;
    logic [7:0] exp_b;

    always @(negedge clk) begin
        if (pclk && !p_pclk && href) begin
            if (sb_q.size() == 0) begin
                chk("sb_underflow", sb_q.size(), 1);
            end else begin
                exp_b = sb_q.pop_front();
                chk("data", data, exp_b);
            end
        end
        if (vsync && !p_vs) begin
            vs_rises++;
            vs_rise_c  = cyc;
            first_line = 1'b1;
        end
        if (!vsync && p_vs) begin
            if (!rst) chk("vsync_len", cyc - vs_rise_c, VS * DV);
            vs_fall_c = cyc;
        end
        if (href && !p_href) begin
            href_rises++;
            if (first_line) chk("vbp_gap", cyc - vs_fall_c, VBP * DV);
            else            chk("hblank_len", cyc - href_fall_c, HB * DV);
            first_line  = 1'b0;
            href_rise_c = cyc;
        end
        if (!href && p_href) begin
            href_fall_c = cyc;
            if (!rst) chk("href_len", cyc - href_rise_c, 2 * W * DV);
        end
        if (fd && !p_fd) begin
            fd_count++;
            chk("frame_len", cyc - vs_rise_c, FRAME_TICKS * DV);
        end
        p_pclk = pclk;
        p_vs   = vsync;
        p_href = href;
        p_fd   = fd;
    end

    // DUT2 monitor: scoreboard plus capture of the frame for pixel-position checks
    logic p2_pclk = 1'b0, p2_vs = 1'b0, p2_href = 1'b0, p2_fd = 1'b0;
    int   row2 = 0, b2 = 0, fd2_count = 0;
    logic [7:0] cap2 [H2][2*W2];
    logic [7:0] exp_b2;

    always @(negedge clk) begin
        if (vsync2 && !p2_vs) row2 = 0;
        if (href2 && !p2_href) b2 = 0;
        if (pclk2 && !p2_pclk && href2) begin
            if (row2 < H2 && b2 < 2 * W2) cap2[row2][b2] = data2;
            b2++;
            if (sb_q2.size() == 0) begin
                chk("sb2_underflow", sb_q2.size(), 1);
            end else begin
                exp_b2 = sb_q2.pop_front();
                chk("data2", data2, exp_b2);
            end
        end
        if (!href2 && p2_href) row2++;
        if (fd2 && !p2_fd) fd2_count++;
        p2_pclk = pclk2;
        p2_vs   = vsync2;
        p2_href = href2;
        p2_fd   = fd2;
    end

    function automatic int cur(input int which);
        case (which)
            0:       return vs_rises;
            1:       return href_rises;
            2:       return fd_count;
            default: return fd2_count;
        endcase
    endfunction

    task automatic wait_count(input string tag, input int which, input int target, input int budget);
        int n = 0;
        while (cur(which) < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (cur(which) < target) chk(tag, cur(which), target);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time %0t exceeded limit 1000000", $time);
        $fatal(1);
    end

    initial begin
        int s_vs, s_h, s_fd;
        en = 1'b0; en2 = 1'b0; psel = '0; psel2 = '0; solid = '0; solid2 = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_pclk", pclk, 0);
        chk("rst_vsync", vsync, 0);
        chk("rst_href", href, 0);
        chk("rst_data", data, 0);
        chk("rst_fd", fd, 0);
        chk("rst_fcnt", fcnt, 0);
        chk("rst_busy", busy, 0);

        // 1: pclk low 2 / high 2, idle stays quiet
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk("pclk_phase", pclk, (k % 4) >= 2);
        end
        s_vs = vs_rises;
        repeat (200) @(negedge clk);
        chk("idle_vsync_rises", vs_rises - s_vs, 0);
        chk("idle_busy", busy, 0);

        // 2: solid A5C3, single frame
        psel = 2'd0; solid = 16'hA5C3;
        push_frame(1, 0, 16'hA5C3, W, H);
        s_vs = vs_rises; s_h = href_rises; s_fd = fd_count;
        en = 1'b1;
        wait_count("t2_vsync_start", 0, s_vs + 1, 50);
        chk("t2_busy_run", busy, 1);
        en = 1'b0;
        wait_count("t2_frame_done", 2, s_fd + 1, FRAME_TICKS * DV + 100);
        repeat (20) @(negedge clk);
        chk("t2_href_pulses", href_rises - s_h, H);
        chk("t2_fd_pulses", fd_count - s_fd, 1);
        chk("t2_fcnt", fcnt, 1);
        chk("t2_sb_empty", sb_q.size(), 0);
        chk("t2_busy", busy, 0);

        // 3: colour bars
        psel = 2'd1;
        push_frame(1, 1, 16'h0000, W, H);
        s_vs = vs_rises; s_fd = fd_count;
        en = 1'b1;
        wait_count("t3_vsync_start", 0, s_vs + 1, 50);
        en = 1'b0;
        wait_count("t3_frame_done", 2, s_fd + 1, FRAME_TICKS * DV + 100);
        repeat (20) @(negedge clk);
        chk("t3_fcnt", fcnt, 2);
        chk("t3_sb_empty", sb_q.size(), 0);

        // 4: checkerboard on the 64x32 instance
        psel2 = 2'd3;
        push_frame(2, 3, 16'h0000, W2, H2);
        en2 = 1'b1;
        repeat (8) @(negedge clk);
        en2 = 1'b0;
        wait_count("t4_frame_done", 3, 1, 20000);
        repeat (20) @(negedge clk);
        chk("t4_r0_p15_hi", cap2[0][30], 8'hFF);
        chk("t4_r0_p15_lo", cap2[0][31], 8'hFF);
        chk("t4_r0_p16_hi", cap2[0][32], 8'h00);
        chk("t4_r0_p16_lo", cap2[0][33], 8'h00);
        chk("t4_r16_p0_hi", cap2[16][0], 8'h00);
        chk("t4_r16_p0_lo", cap2[16][1], 8'h00);
        chk("t4_r16_p16_hi", cap2[16][32], 8'hFF);
        chk("t4_fcnt2", fcnt2, 1);
        chk("t4_sb2_empty", sb_q2.size(), 0);

        // 5: drop enable and change pattern during line 1
        psel = 2'd2; solid = 16'h0000;
        push_frame(1, 2, 16'h0000, W, H);
        s_h = href_rises; s_fd = fd_count;
        en = 1'b1;
        wait_count("t5_line1", 1, s_h + 2, FRAME_TICKS * DV);
        en = 1'b0; psel = 2'd3; solid = 16'h1234;
        wait_count("t5_frame_done", 2, s_fd + 1, FRAME_TICKS * DV + 100);
        repeat (20) @(negedge clk);
        chk("t5_fd_pulses", fd_count - s_fd, 1);
        chk("t5_fcnt", fcnt, 3);
        chk("t5_busy", busy, 0);
        chk("t5_sb_empty", sb_q.size(), 0);
        s_vs = vs_rises;
        repeat (200) @(negedge clk);
        chk("t5_no_restart", vs_rises - s_vs, 0);

        // 6: asynchronous reset mid-ACTIVE
        psel = 2'd0; solid = 16'h5A3C;
        push_frame(1, 0, 16'h5A3C, W, H);
        s_h = href_rises;
        en = 1'b1;
        wait_count("t6_href", 1, s_h + 1, FRAME_TICKS * DV);
        repeat (10) @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_href", href, 0);
        chk("t6_vsync", vsync, 0);
        chk("t6_data", data, 0);
        chk("t6_pclk", pclk, 0);
        chk("t6_fcnt", fcnt, 0);
        chk("t6_busy", busy, 0);
        @(negedge clk);
        en = 1'b0;
        sb_q.delete();
        push_frame(1, 0, 16'h5A3C, W, H);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        s_vs = vs_rises; s_h = href_rises; s_fd = fd_count;
        en = 1'b1;
        wait_count("t6_vsync_start", 0, s_vs + 1, 50);
        en = 1'b0;
        wait_count("t6_frame_done", 2, s_fd + 1, FRAME_TICKS * DV + 100);
        repeat (20) @(negedge clk);
        chk("t6_href_pulses", href_rises - s_h, H);
        chk("t6_fcnt_after", fcnt, 1);
        chk("t6_sb_empty", sb_q.size(), 0);
        chk("t6_busy_after", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
